// File: rtl/dtw_core_ctrl_if.sv
// Controller-side bundle: source FIFO, datapath and sink FIFO signals.
interface dtw_core_ctrl_if #(
   parameter int WIDTH      = 16,
   parameter int AXIS_WIDTH = 32
);
   logic                  src_fifo_clear;
   logic                  src_fifo_rden;
   logic                  src_fifo_empty;
   logic [AXIS_WIDTH-1:0] src_fifo_data;
   logic                  dp_rst;
   logic                  dp_running;
   logic [WIDTH-1:0]      dp_din;
   logic [WIDTH-1:0]      dp_minval;
   logic [31:0]           dp_position;
   logic                  dp_done;
   logic                  sink_fifo_wren;
   logic                  sink_fifo_full;
   logic [AXIS_WIDTH-1:0] sink_fifo_data;
   logic                  sink_fifo_last;

   modport master (
      output src_fifo_clear, src_fifo_rden,
      input  src_fifo_empty, src_fifo_data,
      output dp_rst, dp_running, dp_din,
      input  dp_minval, dp_position, dp_done,
      output sink_fifo_wren, sink_fifo_data, sink_fifo_last,
      input  sink_fifo_full
   );

   modport slave (
      input  src_fifo_clear, src_fifo_rden,
      output src_fifo_empty, src_fifo_data,
      input  dp_rst, dp_running, dp_din,
      output dp_minval, dp_position, dp_done,
      input  sink_fifo_wren, sink_fifo_data, sink_fifo_last,
      output sink_fifo_full
   );
endinterface

// File: rtl/dtw_core_ctrl.sv
// Sequences one subsequence-DTW query: reference-load handshake, header and
// sample pops into the datapath, reference addressing, and a 4-word result
// record pushed to the sink FIFO under valid/full flow control.
module dtw_core_ctrl #(
   parameter int WIDTH            = 16,
   parameter int AXIS_WIDTH       = 32,
   parameter int SQG_SIZE_MAX     = 250,
   parameter int REFMEM_PTR_WIDTH = 20
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rs,
   input  logic                        op_mode,
   input  logic [15:0]                 sqg_len,
   input  logic [WIDTH-1:0]            threshold,
   input  logic                        abort,
   output logic                        busy,
   input  logic                        load_done,
   output logic                        dtw_done,
   output logic [REFMEM_PTR_WIDTH-1:0] addr_ref,
   output logic [31:0]                 query_count,
   dtw_core_ctrl_if.master             bus
);

   typedef enum logic [2:0] {IDLE, REF_LOAD, Q_INIT, Q_LOAD, Q_STREAM, Q_EMIT} state_t;

   state_t                      state, state_nxt;
   logic                        pop, running, accept;
   logic [15:0]                 len_in, len_q, scnt;
   logic [WIDTH-1:0]            thr_q, min_q;
   logic                        match_q;
   logic [AXIS_WIDTH-1:0]       qid_q, w2, word_nxt, sink_data_q;
   logic [31:0]                 pos_q, cyc_q, cyc_cnt, cyc_inc;
   logic [REFMEM_PTR_WIDTH-1:0] addr_inc;
   logic [1:0]                  widx;
   logic                        wren_q, last_q, clear_q, dp_rst_q;

   // zero or oversize lengths both run a full-size query
   assign len_in   = (sqg_len == 16'd0 || sqg_len > 16'(SQG_SIZE_MAX)) ? 16'(SQG_SIZE_MAX) : sqg_len;
   assign cyc_inc  = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + 32'd1;
   assign addr_inc = (addr_ref == '1) ? addr_ref : addr_ref + REFMEM_PTR_WIDTH'(1);
   assign accept   = wren_q & ~bus.sink_fifo_full;

   assign bus.src_fifo_rden  = pop;
   assign bus.dp_running     = running;
   assign bus.dp_din         = bus.src_fifo_data[WIDTH-1:0];
   assign bus.src_fifo_clear = clear_q;
   assign bus.dp_rst         = dp_rst_q;
   assign bus.sink_fifo_wren = wren_q;
   assign bus.sink_fifo_data = sink_data_q;
   assign bus.sink_fifo_last = last_q;

   // record word that follows the one currently presented
   always_comb begin
      w2                = '0;
      w2[WIDTH-1:0]     = min_q;
      w2[AXIS_WIDTH-1]  = match_q;
      case (widx)
         2'd0:    word_nxt = AXIS_WIDTH'(pos_q);
         2'd1:    word_nxt = w2;
         default: word_nxt = AXIS_WIDTH'(cyc_q);
      endcase
   end

   // next state plus the combinational pop / advance strobes
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      running   = 1'b0;
      case (state)
         IDLE: begin
            // the dtw_done cycle is not an acceptance slot, so IDLE is
            // always observable between two queries
            if (rs && !dtw_done) begin
               if (!op_mode && load_done)     state_nxt = Q_INIT;
               else if (op_mode && !load_done) state_nxt = REF_LOAD;
            end
         end
         REF_LOAD: if (load_done) state_nxt = IDLE;
         Q_INIT: begin
            pop = ~bus.src_fifo_empty & ~abort;
            if (pop) state_nxt = Q_LOAD;
         end
         Q_LOAD: begin
            pop     = ~bus.src_fifo_empty & ~abort;
            running = pop;
            if (pop && scnt == len_q - 16'd1) state_nxt = Q_STREAM;
         end
         Q_STREAM: begin
            running = 1'b1;
            if (bus.dp_done) state_nxt = Q_EMIT;
         end
         Q_EMIT: if (accept && widx == 2'd3) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort && state != IDLE) state_nxt = IDLE;
   end

   // state register, registered outputs and query bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         clear_q     <= 1'b1;
         dp_rst_q    <= 1'b1;
         dtw_done    <= 1'b0;
         addr_ref    <= '0;
         query_count <= '0;
         wren_q      <= 1'b0;
         sink_data_q <= '0;
         last_q      <= 1'b0;
         widx        <= '0;
         len_q       <= 16'd1;
         scnt        <= '0;
         thr_q       <= '0;
         min_q       <= '0;
         match_q     <= 1'b0;
         qid_q       <= '0;
         pos_q       <= '0;
         cyc_q       <= '0;
         cyc_cnt     <= '0;
      end else begin
         state    <= state_nxt;
         busy     <= (state_nxt != IDLE);
         clear_q  <= (state_nxt == IDLE);
         dp_rst_q <= (state_nxt == IDLE) || (state_nxt == REF_LOAD);
         dtw_done <= 1'b0;

         if (state == IDLE && state_nxt == Q_INIT) begin
            len_q <= len_in;
            thr_q <= threshold;
         end

         if (state == Q_INIT && pop) begin
            qid_q   <= bus.src_fifo_data;
            cyc_cnt <= '0;
            scnt    <= '0;
         end

         if (state == Q_LOAD || state == Q_STREAM) cyc_cnt <= cyc_inc;
         if (state == Q_LOAD && pop)               scnt    <= scnt + 16'd1;

         if (state_nxt == IDLE)
            addr_ref <= '0;
         else if ((state == Q_LOAD && pop) || state == Q_STREAM)
            addr_ref <= addr_inc;

         if (state == Q_STREAM && bus.dp_done && !abort) begin
            min_q       <= bus.dp_minval;
            pos_q       <= bus.dp_position;
            match_q     <= (bus.dp_minval <= thr_q);
            cyc_q       <= cyc_inc;
            wren_q      <= 1'b1;
            sink_data_q <= qid_q;
            last_q      <= 1'b0;
            widx        <= '0;
         end

         if (state == Q_EMIT) begin
            if (abort) begin
               wren_q      <= 1'b0;
               last_q      <= 1'b0;
               sink_data_q <= '0;
            end else if (accept) begin
               if (widx == 2'd3) begin
                  wren_q      <= 1'b0;
                  last_q      <= 1'b0;
                  sink_data_q <= '0;
                  dtw_done    <= 1'b1;
                  query_count <= query_count + 32'd1;
               end else begin
                  widx        <= widx + 2'd1;
                  sink_data_q <= word_nxt;
                  last_q      <= (widx == 2'd2);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_dtw_core_ctrl.sv
// Directed bench for dtw_core_ctrl: FIFO/datapath/sink models driven by
// hand-timed vectors, each scenario checked against hand-computed values.
module tb_dtw_core_ctrl;

   logic        clk;
   logic        rst, rs, op_mode, abort, load_done;
   logic [15:0] sqg_len, threshold;
   logic        busy, dtw_done;
   logic [19:0] addr_ref;
   logic [31:0] query_count;

   int checks = 0;
   int fails  = 0;

   dtw_core_ctrl_if #(.WIDTH(16), .AXIS_WIDTH(32)) bus ();

   dtw_core_ctrl #(.WIDTH(16), .AXIS_WIDTH(32), .SQG_SIZE_MAX(8), .REFMEM_PTR_WIDTH(20)) dut (
      .clk(clk), .rst(rst), .rs(rs), .op_mode(op_mode), .sqg_len(sqg_len),
      .threshold(threshold), .abort(abort), .busy(busy), .load_done(load_done),
      .dtw_done(dtw_done), .addr_ref(addr_ref), .query_count(query_count), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // source FIFO model (FWFT, cleared by src_fifo_clear)
   logic [31:0] mem [32];
   logic [4:0]  rd_ptr = '0;
   logic [4:0]  wr_ptr;
   logic        stall;
   assign bus.src_fifo_empty = stall || (rd_ptr == wr_ptr);
   assign bus.src_fifo_data  = mem[rd_ptr];

   // pop / clear handling for the FIFO model
   always @(posedge clk) begin
      if (bus.src_fifo_clear)     rd_ptr <= wr_ptr;
      else if (bus.src_fifo_rden) rd_ptr <= rd_ptr + 5'd1;
   end

   // sink and datapath-input monitors
   logic [31:0] rec   [64];
   logic        rlast [64];
   logic [15:0] din_log [64];
   int nrec = 0, spop = 0, wren_cyc = 0;
   always @(posedge clk) begin
      if (bus.sink_fifo_wren) wren_cyc <= wren_cyc + 1;
      if (bus.sink_fifo_wren && !bus.sink_fifo_full) begin
         rec[nrec]   <= bus.sink_fifo_data;
         rlast[nrec] <= bus.sink_fifo_last;
         nrec        <= nrec + 1;
      end
      if (bus.src_fifo_rden && bus.dp_running) begin
         din_log[spop] <= bus.dp_din;
         spop          <= spop + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic push(input logic [31:0] w);
      mem[wr_ptr] = w;
      wr_ptr = wr_ptr + 5'd1;
   endtask

   // accept a query, then fill the FIFO with header + n samples
   task automatic launch(input logic [15:0] len, input logic [15:0] thr, input logic [31:0] hdr, input int n);
      sqg_len = len; threshold = thr; op_mode = 1'b0; rs = 1'b1;
      tick();
      rs = 1'b0;
      push(hdr);
      for (int i = 0; i < n; i++) push(32'hABCD_0100 + 32'(i));
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ticks(3);
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b exp 0", busy); end
      checks++; if (bus.src_fifo_clear !== 1'b1) begin fails++; $display("FAIL rst_clear: got %b exp 1", bus.src_fifo_clear); end
      checks++; if (bus.dp_rst !== 1'b1) begin fails++; $display("FAIL rst_dp_rst: got %b exp 1", bus.dp_rst); end
      checks++; if (bus.sink_fifo_wren !== 1'b0) begin fails++; $display("FAIL rst_wren: got %b exp 0", bus.sink_fifo_wren); end
      checks++; if (addr_ref !== 20'd0) begin fails++; $display("FAIL rst_addr: got %0h exp 0", addr_ref); end
      checks++; if (query_count !== 32'd0) begin fails++; $display("FAIL rst_qcount: got %0d exp 0", query_count); end
      rst = 1'b0;
      tick();
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_idle_busy: got %b exp 0", busy); end
   endtask

   task automatic test_ref_load();
      op_mode = 1'b1; load_done = 1'b0; rs = 1'b1;
      tick();
      rs = 1'b0;
      for (int i = 0; i < 10; i++) begin
         checks++; if (busy !== 1'b1) begin fails++; $display("FAIL ref_busy[%0d]: got %b exp 1", i, busy); end
         checks++; if (bus.src_fifo_clear !== 1'b0) begin fails++; $display("FAIL ref_clear[%0d]: got %b exp 0", i, bus.src_fifo_clear); end
         if (i == 9) load_done = 1'b1;
         tick();
      end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL ref_end_busy: got %b exp 0", busy); end
      checks++; if (bus.src_fifo_clear !== 1'b1) begin fails++; $display("FAIL ref_end_clear: got %b exp 1", bus.src_fifo_clear); end
      op_mode = 1'b0;
      tick();
   endtask

   task automatic test_query();
      int b, w, sp;
      b = nrec; w = wren_cyc; sp = spop;
      launch(16'd4, 16'h20, 32'h7, 4);
      checks++; if (busy !== 1'b1) begin fails++; $display("FAIL q_busy: got %b exp 1", busy); end
      @(negedge clk);
      checks++; if (bus.src_fifo_rden !== 1'b1) begin fails++; $display("FAIL q_hdr_rden: got %b exp 1", bus.src_fifo_rden); end
      checks++; if (bus.dp_running !== 1'b0) begin fails++; $display("FAIL q_hdr_running: got %b exp 0", bus.dp_running); end
      ticks(5);
      checks++; if (addr_ref !== 20'd4) begin fails++; $display("FAIL q_addr4: got %0d exp 4", addr_ref); end
      checks++; if (spop - sp !== 4) begin fails++; $display("FAIL q_pops: got %0d exp 4", spop - sp); end
      checks++; if (din_log[sp] !== 16'h0100) begin fails++; $display("FAIL q_din0: got %0h exp 100", din_log[sp]); end
      checks++; if (din_log[sp+3] !== 16'h0103) begin fails++; $display("FAIL q_din3: got %0h exp 103", din_log[sp+3]); end
      ticks(5);
      bus.dp_done = 1'b1; bus.dp_minval = 16'h0010; bus.dp_position = 32'h123;
      tick();
      bus.dp_done = 1'b0;
      checks++; if (bus.sink_fifo_wren !== 1'b1 || bus.sink_fifo_data !== 32'h7) begin
         fails++; $display("FAIL q_w0: got wren %b data %0h exp 1 7", bus.sink_fifo_wren, bus.sink_fifo_data); end
      ticks(4);
      checks++; if (dtw_done !== 1'b1) begin fails++; $display("FAIL q_done: got %b exp 1", dtw_done); end
      checks++; if (query_count !== 32'd1) begin fails++; $display("FAIL q_count: got %0d exp 1", query_count); end
      checks++; if (nrec - b !== 4) begin fails++; $display("FAIL q_nrec: got %0d exp 4", nrec - b); end
      checks++; if (rec[b] !== 32'h7 || rec[b+1] !== 32'h123 || rec[b+2] !== 32'h8000_0010 || rec[b+3] !== 32'd10) begin
         fails++; $display("FAIL q_words: got %0h %0h %0h %0h exp 7 123 80000010 a", rec[b], rec[b+1], rec[b+2], rec[b+3]); end
      checks++; if ({rlast[b], rlast[b+1], rlast[b+2], rlast[b+3]} !== 4'b0001) begin
         fails++; $display("FAIL q_last: got %b%b%b%b exp 0001", rlast[b], rlast[b+1], rlast[b+2], rlast[b+3]); end
      checks++; if (wren_cyc - w !== 4) begin fails++; $display("FAIL q_emit_len: got %0d exp 4", wren_cyc - w); end
      tick();
      checks++; if (dtw_done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL q_after: got done %b busy %b exp 0 0", dtw_done, busy); end
   endtask

   task automatic test_sink_stall();
      int b, w;
      b = nrec; w = wren_cyc;
      launch(16'd4, 16'h20, 32'hA5, 4);
      ticks(10);
      bus.dp_done = 1'b1; bus.dp_minval = 16'h0030; bus.dp_position = 32'h456;
      tick();
      bus.dp_done = 1'b0;
      tick();
      bus.sink_fifo_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.sink_fifo_wren !== 1'b1 || bus.sink_fifo_data !== 32'h456 || bus.sink_fifo_last !== 1'b0) begin
            fails++; $display("FAIL stall_hold[%0d]: got wren %b data %0h last %b exp 1 456 0", i, bus.sink_fifo_wren, bus.sink_fifo_data, bus.sink_fifo_last); end
         tick();
      end
      bus.sink_fifo_full = 1'b0;
      checks++; if (bus.sink_fifo_data !== 32'h456) begin fails++; $display("FAIL stall_release: got %0h exp 456", bus.sink_fifo_data); end
      tick();
      checks++; if (bus.sink_fifo_data !== 32'h0000_0030) begin fails++; $display("FAIL stall_w2: got %0h exp 30", bus.sink_fifo_data); end
      tick();
      checks++; if (bus.sink_fifo_data !== 32'd10 || bus.sink_fifo_last !== 1'b1) begin
         fails++; $display("FAIL stall_w3: got %0h last %b exp a 1", bus.sink_fifo_data, bus.sink_fifo_last); end
      tick();
      checks++; if (dtw_done !== 1'b1 || query_count !== 32'd2) begin
         fails++; $display("FAIL stall_done: got done %b count %0d exp 1 2", dtw_done, query_count); end
      checks++; if (wren_cyc - w !== 7) begin fails++; $display("FAIL stall_emit_len: got %0d exp 7", wren_cyc - w); end
      checks++; if (nrec - b !== 4 || rec[b] !== 32'hA5 || rec[b+1] !== 32'h456) begin
         fails++; $display("FAIL stall_rec: got n %0d w0 %0h w1 %0h exp 4 a5 456", nrec - b, rec[b], rec[b+1]); end
      ticks(2);
   endtask

   task automatic test_abort();
      int w, sp;
      w = wren_cyc; sp = spop;
      launch(16'd4, 16'h20, 32'h99, 4);
      ticks(2);
      abort = 1'b1;
      @(negedge clk);
      checks++; if (bus.src_fifo_rden !== 1'b0 || bus.dp_running !== 1'b0) begin
         fails++; $display("FAIL abort_pop: got rden %b running %b exp 0 0", bus.src_fifo_rden, bus.dp_running); end
      tick();
      abort = 1'b0;
      checks++; if (busy !== 1'b0 || bus.src_fifo_clear !== 1'b1 || addr_ref !== 20'd0) begin
         fails++; $display("FAIL abort_idle: got busy %b clear %b addr %0d exp 0 1 0", busy, bus.src_fifo_clear, addr_ref); end
      checks++; if (spop - sp !== 1) begin fails++; $display("FAIL abort_pops: got %0d exp 1", spop - sp); end
      ticks(3);
      checks++; if (wren_cyc - w !== 0 || dtw_done !== 1'b0 || query_count !== 32'd2) begin
         fails++; $display("FAIL abort_quiet: got wren_cyc %0d done %b count %0d exp 0 0 2", wren_cyc - w, dtw_done, query_count); end
   endtask

   task automatic test_clamp_empty();
      int sp;
      sp = spop;
      launch(16'd0, 16'h20, 32'h55, 8);
      ticks(4);
      checks++; if (addr_ref !== 20'd3) begin fails++; $display("FAIL clamp_addr3: got %0d exp 3", addr_ref); end
      stall = 1'b1;
      @(negedge clk);
      checks++; if (bus.dp_running !== 1'b0 || bus.src_fifo_rden !== 1'b0) begin
         fails++; $display("FAIL clamp_empty0: got running %b rden %b exp 0 0", bus.dp_running, bus.src_fifo_rden); end
      tick();
      @(negedge clk);
      checks++; if (bus.dp_running !== 1'b0) begin fails++; $display("FAIL clamp_empty1: got %b exp 0", bus.dp_running); end
      tick();
      checks++; if (addr_ref !== 20'd3) begin fails++; $display("FAIL clamp_addr_hold: got %0d exp 3", addr_ref); end
      stall = 1'b0;
      ticks(5);
      checks++; if (addr_ref !== 20'd8) begin fails++; $display("FAIL clamp_addr8: got %0d exp 8", addr_ref); end
      checks++; if (spop - sp !== 8) begin fails++; $display("FAIL clamp_pops: got %0d exp 8", spop - sp); end
      checks++; if (bus.dp_running !== 1'b1) begin fails++; $display("FAIL clamp_stream_run: got %b exp 1", bus.dp_running); end
      tick();
      checks++; if (addr_ref !== 20'd9) begin fails++; $display("FAIL clamp_stream_addr: got %0d exp 9", addr_ref); end
   endtask

   // entered while the DUT is still in Q_STREAM from the clamp scenario
   task automatic test_reset_mid_stream();
      rst = 1'b1;
      tick();
      checks++; if (busy !== 1'b0 || dtw_done !== 1'b0 || addr_ref !== 20'd0 || query_count !== 32'd0) begin
         fails++; $display("FAIL mid_rst_ctl: got busy %b done %b addr %0d count %0d exp 0 0 0 0", busy, dtw_done, addr_ref, query_count); end
      checks++; if (bus.src_fifo_clear !== 1'b1 || bus.src_fifo_rden !== 1'b0 || bus.dp_rst !== 1'b1 || bus.dp_running !== 1'b0) begin
         fails++; $display("FAIL mid_rst_dp: got clear %b rden %b dp_rst %b running %b exp 1 0 1 0",
                           bus.src_fifo_clear, bus.src_fifo_rden, bus.dp_rst, bus.dp_running); end
      checks++; if (bus.sink_fifo_wren !== 1'b0 || bus.sink_fifo_data !== 32'd0 || bus.sink_fifo_last !== 1'b0) begin
         fails++; $display("FAIL mid_rst_sink: got wren %b data %0h last %b exp 0 0 0", bus.sink_fifo_wren, bus.sink_fifo_data, bus.sink_fifo_last); end
      rst = 1'b0;
      tick();
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_rst_idle: got %b exp 0", busy); end
   endtask

   initial begin
      rst = 1'b1; rs = 1'b0; op_mode = 1'b0; sqg_len = '0; threshold = '0;
      abort = 1'b0; load_done = 1'b0; stall = 1'b0; wr_ptr = '0;
      bus.dp_minval = '0; bus.dp_position = '0; bus.dp_done = 1'b0; bus.sink_fifo_full = 1'b0;
      test_reset();
      test_ref_load();
      test_query();
      test_sink_stall();
      test_abort();
      test_clamp_empty();
      test_reset_mid_stream();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/dtw_core_ctrl.md
# dtw_core_ctrl

Parametrised successor to the single-query DTW core controller: it sequences one subsequence-DTW query through an external `dtw_core_datapath` instance. It handles the reference-load handshake, pops the query header and samples from the source FIFO, and drives the reference address counter. It then emits a 4-word result record (query id, position, flagged min value, cycle count) to the sink FIFO with a proper valid/full handshake. New relative to the previous core: runtime query length, match-threshold flag, cycle-count reporting, abort, a completed-query counter, and stall-safe output.

## Interface
- `WIDTH`, 16, sample / min-value width (≤ 31)
- `AXIS_WIDTH`, 32, control word width
- `SQG_SIZE_MAX`, 250, maximum query samples; `sqg_len` is clamped to this
- `REFMEM_PTR_WIDTH`, 20, reference address width
- Clock/reset: single clock; reset is synchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `rs`  in  1  run/start request, sampled in IDLE only
- `op_mode`  in  1  0 = query, 1 = load reference
- `sqg_len`  in  16  query sample count; latched on IDLE→Q_INIT
- `threshold`  in  WIDTH  match threshold, unsigned; latched with `sqg_len`
- `abort`  in  1  cancel the current operation
- `busy`  out  1  high in every state except IDLE
- `load_done`  in  1  reference memory loaded
- `dtw_done`  out  1  one-cycle pulse when the record's last word is accepted
- `addr_ref`  out  REFMEM_PTR_WIDTH  reference address
- `query_count`  out  32  completed queries since reset (wraps)
- `src_fifo_clear`  out  1  clear the source FIFO
- `src_fifo_rden`  out  1  pop; FWFT FIFO, data valid while `!src_fifo_empty`
- `src_fifo_empty`  in  1  source FIFO empty
- `src_fifo_data`  in  32  source FIFO data
- `dp_rst`  out  1  datapath reset
- `dp_running`  out  1  datapath advance enable
- `dp_din`  out  WIDTH  `src_fifo_data[WIDTH-1:0]`, combinational
- `dp_minval`  in  WIDTH  datapath minimum cost
- `dp_position`  in  32  datapath best position
- `dp_done`  in  1  datapath finished
- `sink_fifo_wren`  out  1  write valid
- `sink_fifo_full`  in  1  sink full
- `sink_fifo_data`  out  32  write data
- `sink_fifo_last`  out  1  high with the 4th record word

## Operation
- States: IDLE, REF_LOAD, Q_INIT, Q_LOAD, Q_STREAM, Q_EMIT.
- **IDLE**
  - Outputs: `busy`=0, `src_fifo_clear`=1, `dp_rst`=1, `addr_ref`=0.
  - `rs` & `op_mode`=0 & `load_done` → Q_INIT.
  - `rs` & `op_mode`=1 & `!load_done` → REF_LOAD.
  - Any other combination: stay in IDLE.
- **REF_LOAD**
  - Outputs: `busy`=1, `src_fifo_clear`=0, `dp_rst`=1.
  - `load_done` → IDLE.
- **Q_INIT**
  - `dp_rst`=0.
  - On `!empty`: pop the header, latch qid = `src_fifo_data`, clear the cycle counter, → Q_LOAD.
- **Q_LOAD**
  - Each cycle with `!empty`: pop, `dp_running`=1, `addr_ref`+1, sample count+1.
  - Empty cycle: no pop, `dp_running`=0.
  - After the Lth sample pop → Q_STREAM. L = `sqg_len` clamped to `SQG_SIZE_MAX`; 0 is treated as `SQG_SIZE_MAX`.
- **Q_STREAM**
  - `dp_running`=1 and `addr_ref`+1 every cycle.
  - `dp_done` → Q_EMIT: latch `dp_minval`, `dp_position`, cycle count.
  - Match = `dp_minval` ≤ threshold.
- **Q_EMIT**
  - `sink_fifo_wren`=1 with the current word.
  - Word index advances only on `wren & !full`; data and last are held stable while full.
  - Words:
    - W0 = qid
    - W1 = position
    - W2 = {match, zeros, minval[WIDTH-1:0]}
    - W3 = cycle count, `last`=1
  - On W3 accepted: `dtw_done` pulse, `query_count`+1, → IDLE.
- **abort**
  - In any non-IDLE state: → IDLE next cycle, no further pops or writes, no `dtw_done`, `query_count` unchanged.
  - Abort beats `dp_done` and beats a W3 accept in the same cycle.
- **Arithmetic and widths**
  - `addr_ref` saturates at all-ones.
  - Cycle counter (32-bit) counts Q_LOAD+Q_STREAM cycles, including the `dp_done` cycle; it saturates.
  - `query_count` wraps.

## Timing
- Reset values: `busy` 0, `dtw_done` 0, `addr_ref` 0, `query_count` 0, `src_fifo_clear` 1, `src_fifo_rden` 0, `dp_rst` 1, `dp_running` 0, `sink_fifo_wren` 0, `sink_fifo_data` 0, `sink_fifo_last` 0; state IDLE.
- `src_fifo_rden` and `dp_running` in Q_INIT/Q_LOAD are combinational from `!src_fifo_empty & !abort`, so the datapath consumes `dp_din` in the pop cycle.
- All other outputs are registered.
- `busy` rises the cycle after the `rs` acceptance.
- Unstalled query: 1 header cycle + L load cycles; Q_STREAM length is set by the datapath.
- Emit: 4 cycles minimum, plus 1 per full cycle.
- Back-to-back: a new `rs` is accepted no earlier than the second cycle after `dtw_done`, because IDLE lasts at least one cycle.

## Test plan
- Reset: assert `rst` mid-Q_STREAM → next cycle all outputs at their reset values, state IDLE.
- Ref load: `op_mode`=1, `rs`, `load_done`=0 for 10 cycles then 1 → `busy` 1 for those cycles, then 0; `src_fifo_clear` 0 while busy.
- Query, L=4, threshold=0x20, FIFO holds qid 0x7 + 4 samples, model `dp_done` 6 cycles into Q_STREAM with minval 0x0010, pos 0x123 → words 0x7, 0x123, 0x80000010, 10; `last` only on the 4th; `query_count`=1.
- Sink stall: `full` high for 3 cycles while W1 is presented → W1 held stable, W2 appears only after the accept; total emit 7 cycles.
- Abort: `abort` on the 2nd Q_LOAD pop → IDLE next cycle, `src_fifo_clear`=1, no `wren`, `query_count` unchanged.
- Clamp/empty: `sqg_len`=0, `SQG_SIZE_MAX`=8, FIFO empty for 2 cycles mid-load → exactly 8 sample pops, `dp_running` low in the empty cycles, `addr_ref`=8 entering Q_STREAM.
